// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic matmul feeder: dimensions, FSM states, lane packing.
// Lane l of a flat bus lives in bits [FLAT_W-1-WORD_W*l -: WORD_W], so lane 0 is the MSB word.
package matmul_pkg;

    localparam int LANES   = 4;
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 4;
    localparam int RUN_LEN = 16;
    localparam int FLAT_W  = LANES * WORD_W;
    localparam int ROW_W   = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } feederState_t;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [LANES-1:0] laneVec_t;

    function automatic word_t getLane(input logic [FLAT_W-1:0] flat, input int lane);
        return flat[FLAT_W-1-WORD_W*lane -: WORD_W];
    endfunction

    function automatic logic [FLAT_W-1:0] packLanes(input laneVec_t vec);
        logic [FLAT_W-1:0] flat;
        flat = '0;
        for (int l = 0; l < LANES; l++) begin
            flat[FLAT_W-1-WORD_W*l -: WORD_W] = vec[l];
        end
        return flat;
    endfunction

endpackage

// File: rtl/matmul_opnd_buf.sv
// 4x4 operand register bank: whole-row write port, one independent element read per lane.
module matmul_opnd_buf
    import matmul_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wrEn,
    input  logic [ROW_W-1:0]            wrRow,
    input  logic [FLAT_W-1:0]           wrData,
    input  logic [LANES-1:0][ROW_W-1:0] rdRow,
    input  logic [LANES-1:0][ROW_W-1:0] rdCol,
    output laneVec_t                    rdData
);

    word_t mem [LANES][LANES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < LANES; r++) begin
                for (int c = 0; c < LANES; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wrEn) begin
            for (int c = 0; c < LANES; c++) begin
                mem[wrRow][c] <= getLane(wrData, c);
            end
        end
    end

    always_comb begin
        rdData = '0;
        for (int l = 0; l < LANES; l++) begin
            rdData[l] = mem[rdRow[l]][rdCol[l]];
        end
    end

endmodule

// File: rtl/matmul_feeder.sv
// Upstream sequencer for the 4x4 systolic array: buffers A and B, then streams skewed lanes on go.
// Define MATMUL_FEED_DBUF_EN for double-buffered operands (loads during a run, go accepted in DONE).
module matmul_feeder
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [ROW_W-1:0]  ld_row,
    input  logic [FLAT_W-1:0] ld_data,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              input_start,
    output logic [CNT_W-1:0]  counter,
    output logic [FLAT_W-1:0] feed_a_flat,
    output logic [FLAT_W-1:0] feed_b_flat
);

    feederState_t state;
    logic ldFire;
    logic goAccept;
    logic [LANES-1:0][ROW_W-1:0] stepIdx;
    logic [LANES-1:0][ROW_W-1:0] laneIdx;
    logic [LANES-1:0] laneOk;
    laneVec_t aRd;
    laneVec_t bRd;
    laneVec_t nextFeedA;
    laneVec_t nextFeedB;

    assign ldFire = ld_valid && ld_ready;

`ifdef MATMUL_FEED_DBUF_EN
    localparam logic READY_IN_RUN = 1'b1;

    logic activeBank;
    logic writeBank;
    laneVec_t aRdBank [2];
    laneVec_t bRdBank [2];

    // A load in the go cycle belongs to the bank that becomes shadow at this edge.
    assign goAccept  = go && (state == IDLE || state == DONE);
    assign writeBank = goAccept ? activeBank : ~activeBank;

    for (genvar b = 0; b < 2; b++) begin : gBank
        matmul_opnd_buf uBufA (
            .clk(clk), .rst(rst),
            .wrEn(ldFire && !ld_sel && (writeBank == 1'(b))),
            .wrRow(ld_row), .wrData(ld_data),
            .rdRow(laneIdx), .rdCol(stepIdx), .rdData(aRdBank[b])
        );
        matmul_opnd_buf uBufB (
            .clk(clk), .rst(rst),
            .wrEn(ldFire && ld_sel && (writeBank == 1'(b))),
            .wrRow(ld_row), .wrData(ld_data),
            .rdRow(stepIdx), .rdCol(laneIdx), .rdData(bRdBank[b])
        );
    end

    assign aRd = aRdBank[activeBank];
    assign bRd = bRdBank[activeBank];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            activeBank <= 1'b0;
        end else if (goAccept) begin
            activeBank <= ~activeBank;
        end
    end
`else
    localparam logic READY_IN_RUN = 1'b0;

    assign goAccept = go && (state == IDLE);

    matmul_opnd_buf uBufA (
        .clk(clk), .rst(rst),
        .wrEn(ldFire && !ld_sel),
        .wrRow(ld_row), .wrData(ld_data),
        .rdRow(laneIdx), .rdCol(stepIdx), .rdData(aRd)
    );
    matmul_opnd_buf uBufB (
        .clk(clk), .rst(rst),
        .wrEn(ldFire && ld_sel),
        .wrRow(ld_row), .wrData(ld_data),
        .rdRow(stepIdx), .rdCol(laneIdx), .rdData(bRd)
    );
`endif

    // The current counter value is the step s fed in the next cycle; lane l carries k = s - l.
    always_comb begin
        stepIdx = '0;
        laneIdx = '0;
        laneOk  = '0;
        for (int l = 0; l < LANES; l++) begin
            stepIdx[l] = ROW_W'(int'(counter) - l);
            laneIdx[l] = ROW_W'(l);
            laneOk[l]  = (state == RUN) && (int'(counter) >= l) && (int'(counter) - l < LANES);
        end
    end

    always_comb begin
        nextFeedA = '0;
        nextFeedB = '0;
        for (int l = 0; l < LANES; l++) begin
            nextFeedA[l] = laneOk[l] ? bRd[l] : '0;
            nextFeedB[l] = laneOk[l] ? aRd[l] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            counter     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            input_start <= 1'b0;
            feed_a_flat <= '0;
            feed_b_flat <= '0;
            ld_ready    <= 1'b0;
        end else begin
            done        <= 1'b0;
            input_start <= 1'b0;
            feed_a_flat <= '0;
            feed_b_flat <= '0;
            case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    counter  <= '0;
                    ld_ready <= 1'b1;
                    if (goAccept) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        input_start <= 1'b1;
                        ld_ready    <= READY_IN_RUN;
                    end
                end
                RUN: begin
                    if (counter == CNT_W'(RUN_LEN - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        counter  <= '0;
                        ld_ready <= 1'b1;
                    end else begin
                        counter     <= counter + CNT_W'(1);
                        feed_a_flat <= packLanes(nextFeedA);
                        feed_b_flat <= packLanes(nextFeedB);
                        ld_ready    <= READY_IN_RUN;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    counter  <= '0;
                    ld_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench for matmul_feeder: stimulus pushes expected run streams, a negedge monitor pops and compares.
module tb_matmul_feeder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic         ld_sel = 1'b0;
    logic [1:0]   ld_row = '0;
    logic [127:0] ld_data = '0;
    logic         go = 1'b0;
    logic         busy;
    logic         done;
    logic         input_start;
    logic [3:0]   counter;
    logic [127:0] feed_a_flat;
    logic [127:0] feed_b_flat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   cnt;
        logic         start;
        logic         bsy;
        logic         dn;
        logic [127:0] fa;
        logic [127:0] fb;
    } expect_t;

    expect_t expQ [$];

    logic [31:0] mA [2][4][4];
    logic [31:0] mB [2][4][4];
    bit          mAct = 1'b0;

    matmul_feeder dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_row(ld_row), .ld_data(ld_data),
        .go(go), .busy(busy), .done(done), .input_start(input_start), .counter(counter),
        .feed_a_flat(feed_a_flat), .feed_b_flat(feed_b_flat)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] makeRow(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3);
        return {w0, w1, w2, w3};
    endfunction

    function automatic void clearModel();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    mA[b][r][c] = '0;
                    mB[b][r][c] = '0;
                end
        mAct = 1'b0;
    endfunction

    // C0 clears, C1..C7 carry skewed steps 0..6, C8..C15 drain, then one DONE cycle.
    function automatic void pushRun();
        expect_t e;
        for (int n = 0; n < 16; n++) begin
            e.cnt = 4'(n); e.start = (n == 0); e.bsy = 1'b1; e.dn = 1'b0;
            e.fa = '0; e.fb = '0;
            for (int l = 0; l < 4; l++) begin
                int k = n - 1 - l;
                if (n >= 1 && k >= 0 && k <= 3) begin
                    e.fa[127-32*l -: 32] = mB[mAct][k][l];
                    e.fb[127-32*l -: 32] = mA[mAct][l][k];
                end
            end
            expQ.push_back(e);
        end
        e.cnt = 4'd0; e.start = 1'b0; e.bsy = 1'b0; e.dn = 1'b1; e.fa = '0; e.fb = '0;
        expQ.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit doLoad, input bit sel, input int row,
                                 input logic [127:0] data, input bit doGo);
        int n = 0;
        bit wb;
        ld_valid = doLoad; ld_sel = sel; ld_row = 2'(row); ld_data = data; go = doGo;
        while (doLoad && !ld_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (doLoad) checks++;
        if (doLoad && !ld_ready) begin
            errors++;
            $display("[TB] FAIL load handshake: ld_ready=0 after %0d cycles, expected 1", n);
        end else begin
            if (doLoad) begin
`ifdef MATMUL_FEED_DBUF_EN
                wb = doGo ? mAct : !mAct;
`else
                wb = 1'b0;
`endif
                for (int c = 0; c < 4; c++) begin
                    if (sel) mB[wb][row][c] = data[127-32*c -: 32];
                    else     mA[wb][row][c] = data[127-32*c -: 32];
                end
            end
            if (doGo) begin
`ifdef MATMUL_FEED_DBUF_EN
                mAct = !mAct;
`endif
                pushRun();
            end
        end
        @(posedge clk); #1;
        ld_valid = 1'b0; go = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL run drain: %0d entries pending after %0d cycles, expected 0", expQ.size(), n);
            expQ.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        expect_t e;
        string lbl;
        if (rst) begin
            if (busy || done) begin
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected output: busy=%0b done=%0b counter=%0d, expected idle",
                             busy, done, counter);
                end else begin
                    e = expQ.pop_front();
                    if (e.dn) lbl = "DONE";
                    else      lbl = $sformatf("C%0d", e.cnt);
                    checkOutput({lbl, " counter"},     128'(counter),     128'(e.cnt));
                    checkOutput({lbl, " input_start"}, 128'(input_start), 128'(e.start));
                    checkOutput({lbl, " busy"},        128'(busy),        128'(e.bsy));
                    checkOutput({lbl, " done"},        128'(done),        128'(e.dn));
                    checkOutput({lbl, " feed_a"},      feed_a_flat,       e.fa);
                    checkOutput({lbl, " feed_b"},      feed_b_flat,       e.fb);
                end
            end else begin
                checkOutput("idle counter/input_start", 128'({counter, input_start}), 128'd0);
                checkOutput("idle feed_a", feed_a_flat, 128'd0);
                checkOutput("idle feed_b", feed_b_flat, 128'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [127:0] rowData;
        clearModel();

        $display("[TB] reset and ld_ready release");
        #2;
        checkOutput("reset flags", 128'({busy, done, input_start, ld_ready, counter}), 128'd0);
        checkOutput("reset feeds", feed_a_flat | feed_b_flat, 128'd0);
        #10 rst = 1'b1;
        #1 checkOutput("ld_ready before first edge", 128'(ld_ready), 128'd0);
        @(posedge clk); #1;
        checkOutput("ld_ready after release", 128'(ld_ready), 128'd1);

        $display("[TB] test 1: identity A, B[r][c]=4r+c+1");
        for (int r = 0; r < 4; r++)
            applyStimulus(1, 0, r, makeRow(32'(r == 0), 32'(r == 1), 32'(r == 2), 32'(r == 3)), 0);
        for (int r = 0; r < 4; r++)
            applyStimulus(1, 1, r, makeRow(4*r+1, 4*r+2, 4*r+3, 4*r+4), 0);
        applyStimulus(0, 0, 0, '0, 1);
        checkOutput("T1 C0 input_start", 128'(input_start), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("T1 C3 feed_a", feed_a_flat, makeRow(9, 6, 3, 0));
        checkOutput("T1 C3 feed_b", feed_b_flat, makeRow(0, 1, 0, 0));
        repeat (4) @(posedge clk);
        #1;
        checkOutput("T1 C7 feed_a", feed_a_flat, makeRow(0, 0, 0, 16));
        repeat (8) @(posedge clk);
        #1;
        checkOutput("T1 C15 counter/done", 128'({counter, done}), 128'({4'd15, 1'b0}));
        @(posedge clk); #1;
        checkOutput("T1 done pulse", 128'({done, busy}), 128'({1'b1, 1'b0}));
        waitDrain();

        $display("[TB] test 2: full-range operand values");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) rowData[127-32*c -: 32] = 32'(32'h9E3779B9 * (4*r + c + 1));
            applyStimulus(1, 0, r, rowData, 0);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) rowData[127-32*c -: 32] = 32'hFFFF0000 + 32'(16*c + r);
            applyStimulus(1, 1, r, rowData, 0);
        end
        applyStimulus(0, 0, 0, '0, 1);
        waitDrain();

        $display("[TB] test 3: reset in the middle of a run");
        applyStimulus(0, 0, 0, '0, 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("T3 counter before reset", 128'(counter), 128'd5);
        #1 rst = 1'b0;
        #1;
        checkOutput("T3 async flags", 128'({busy, done, input_start, ld_ready, counter}), 128'd0);
        checkOutput("T3 async feeds", feed_a_flat | feed_b_flat, 128'd0);
        expQ.delete();
        clearModel();
        @(posedge clk); #2 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, '0, 1);
        waitDrain();

        $display("[TB] test 4: go and load attempt during a run");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1, 0, r, makeRow(10*r+1, 10*r+2, 10*r+3, 10*r+4), 0);
            applyStimulus(1, 1, r, makeRow(100+r, 200+r, 300+r, 400+r), 0);
        end
        applyStimulus(0, 0, 0, '0, 1);
        repeat (4) @(posedge clk);
        #1;
        go = 1'b1;
`ifndef MATMUL_FEED_DBUF_EN
        ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_data = {4{32'hDEADBEEF}};
        checkOutput("T4 ld_ready in RUN", 128'(ld_ready), 128'd0);
`endif
        @(posedge clk); #1;
        go = 1'b0;
        checkOutput("T4 counter after ignored go", 128'(counter), 128'd5);
`ifndef MATMUL_FEED_DBUF_EN
        checkOutput("T4 ld_ready still low", 128'(ld_ready), 128'd0);
        ld_valid = 1'b0;
`endif
        waitDrain();

        $display("[TB] test 5: load and go in the same cycle");
        applyStimulus(1, 0, 1, makeRow(5, 5, 5, 5), 1);
        repeat (2) @(posedge clk);
        #1;
`ifndef MATMUL_FEED_DBUF_EN
        checkOutput("T5 C2 feed_b lane1", 128'(feed_b_flat[95:64]), 128'd5);
`endif
        waitDrain();

`ifdef MATMUL_FEED_DBUF_EN
        $display("[TB] test 6: shadow loads during a run, go in DONE");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1, 0, r, makeRow(r+1, r+2, r+3, r+4), 0);
            applyStimulus(1, 1, r, makeRow(50+r, 60+r, 70+r, 80+r), 0);
        end
        applyStimulus(0, 0, 0, '0, 1);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1, 0, r, makeRow(7*r+3, 7*r+4, 7*r+5, 7*r+6), 0);
            applyStimulus(1, 1, r, makeRow(900+r, 910+r, 920+r, 930+r), 0);
        end
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("T6 reached DONE", 128'(done), 128'd1);
        applyStimulus(0, 0, 0, '0, 1);
        waitDrain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
